// File: rtl/can_tx_frame_fetch.sv
// can_tx_frame_fetch
//   Reader end of the 128-bit CAN TX FIFO. It pops one frame, unpacks the word
//   into CAN frame fields and offers them to the bit-level transmitter over a
//   valid/ready handshake. After an arbitration loss or a bus error it presents
//   the same frame again, up to MAX_RETRIES times, and then drops it.
//
//   FIFO word layout:
//     [127]     ide   extended identifier
//     [126]     rtr   remote frame
//     [125:122] dlc   data length code, passed raw
//     [121:93]  id    identifier; only [103:93] is used for base frames
//     [92:64]   unused
//     [63:0]    data
//
//   Build option CAN_TX_ONE_SHOT_EN: single-shot mode. The first arbitration
//   loss or bus error aborts the frame, and o_retry_cnt stays 0.

module can_tx_frame_fetch #(
  parameter  int MAX_RETRIES = 8,
  localparam int CW          = $clog2(MAX_RETRIES + 1)
) (
  input  logic           i_sys_clk,
  input  logic           i_reset_n,
  input  logic           i_enable,
  input  logic           i_fifo_empty,
  input  logic [127:0]   i_fifo_r_data,
  output logic           o_fifo_r_en,
  output logic           o_tx_valid,
  input  logic           i_tx_ready,
  output logic           o_tx_ide,
  output logic           o_tx_rtr,
  output logic [3:0]     o_tx_dlc,
  output logic [28:0]    o_tx_id,
  output logic [63:0]    o_tx_data,
  input  logic           i_tx_done,
  input  logic           i_tx_arb_lost,
  input  logic           i_tx_error,
  output logic           o_tx_ok,
  output logic           o_tx_abort,
  output logic           o_busy,
  output logic [CW-1:0]  o_retry_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    WAIT_TX = 2'd2
  } state_t;

  state_t state;

  // Field view of the FIFO head word.
  logic        word_ide;
  logic        word_rtr;
  logic [3:0]  word_dlc;
  logic [28:0] word_id;
  logic [63:0] word_data;
  logic        retry_event;

  // Bits [92:64] carry nothing for the transmitter; they are folded here so the
  // drop is explicit rather than accidental.
  logic        unused_word_bits;
  assign unused_word_bits = ^i_fifo_r_data[92:64];

  // Unpack the head word; base frames keep only the 11-bit identifier.
  always_comb begin
    word_ide  = i_fifo_r_data[127];
    word_rtr  = i_fifo_r_data[126];
    word_dlc  = i_fifo_r_data[125:122];
    word_data = i_fifo_r_data[63:0];
    if (i_fifo_r_data[127]) begin
      word_id = i_fifo_r_data[121:93];
    end else begin
      word_id = {18'd0, i_fifo_r_data[103:93]};
    end
  end

  // An arbitration loss and a bus error in the same cycle count as one retry.
  assign retry_event = i_tx_arb_lost | i_tx_error;

`ifndef CAN_TX_ONE_SHOT_EN
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_RETRIES);
`endif

  // Fetch / present / wait-for-completion sequencer with registered outputs.
  // The output field registers double as the frame hold register.
  // NOTE: every assignment in this clocked block is non-blocking so all state
  // and outputs update together from the values present before the edge.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // NOTE: the hold register is cleared on reset even though it is only
      // data; a frame popped before reset is intentionally lost, never replayed.
      state       <= IDLE;
      o_fifo_r_en <= 1'b0;
      o_tx_valid  <= 1'b0;
      o_tx_ide    <= 1'b0;
      o_tx_rtr    <= 1'b0;
      o_tx_dlc    <= '0;
      o_tx_id     <= '0;
      o_tx_data   <= '0;
      o_tx_ok     <= 1'b0;
      o_tx_abort  <= 1'b0;
      o_busy      <= 1'b0;
      o_retry_cnt <= '0;
    end else begin
      // Pulse outputs default low and are raised only for the cycle they mark.
      o_fifo_r_en <= 1'b0;
      o_tx_ok     <= 1'b0;
      o_tx_abort  <= 1'b0;

      case (state)
        IDLE: begin
          if (i_enable && !i_fifo_empty) begin
            o_tx_ide    <= word_ide;
            o_tx_rtr    <= word_rtr;
            o_tx_dlc    <= word_dlc;
            o_tx_id     <= word_id;
            o_tx_data   <= word_data;
            o_tx_valid  <= 1'b1;
            o_fifo_r_en <= 1'b1;
            o_busy      <= 1'b1;
            state       <= PRESENT;
          end
        end

        PRESENT: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            state      <= WAIT_TX;
          end
        end

        WAIT_TX: begin
          if (i_tx_done) begin
            // A successful transmission outranks a same-cycle failure report.
            o_tx_ok     <= 1'b1;
            o_retry_cnt <= '0;
            o_busy      <= 1'b0;
            state       <= IDLE;
          end else if (retry_event) begin
`ifdef CAN_TX_ONE_SHOT_EN
            o_tx_abort  <= 1'b1;
            o_retry_cnt <= '0;
            o_busy      <= 1'b0;
            state       <= IDLE;
`else
            if (o_retry_cnt < MAX_CNT) begin
              o_retry_cnt <= o_retry_cnt + 1'b1;
              o_tx_valid  <= 1'b1;
              state       <= PRESENT;
            end else begin
              o_tx_abort  <= 1'b1;
              o_retry_cnt <= '0;
              o_busy      <= 1'b0;
              state       <= IDLE;
            end
`endif
          end
        end

        default: begin
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
